// File: rtl/crypto1_sched_pkg.sv
// Shared types, widths and helpers for the Crypto1 key-search scheduler.
package crypto1_sched_pkg;

  localparam int KEY_W      = 48;
  localparam int KEY_BITS_W = $clog2(KEY_W);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RST   = 3'd1,
    ST_RUN   = 3'd2,
    ST_SHIFT = 3'd3,
    ST_FOUND = 3'd4,
    ST_EXH   = 3'd5
  } state_t;

  // Priority encoder: index of the lowest set bit, 0 when the vector is empty.
  function automatic logic [7:0] lowest_set(input logic [255:0] vec);
    logic [7:0] idx;
    idx = 8'd0;
    for (int i = 255; i >= 0; i--) begin
      idx = vec[i] ? 8'(i) : idx;
    end
    return idx;
  endfunction

endpackage

// File: rtl/crypto1_key_reader.sv
// Two-phase serial key reader: phase A raises the strobe, phase B waits for the
// core to register its next bit and shifts it in at the end of the phase.
module crypto1_key_reader
  import crypto1_sched_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             data_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             strobe_o,
  output logic [KEY_W-1:0] key_o
);

  logic                  busy_q, busy_d;
  logic                  phase_q, phase_d;
  logic [KEY_BITS_W-1:0] cnt_q, cnt_d;
  logic [KEY_W-1:0]      key_q, key_d;
  logic                  last_s;

  assign last_s   = busy_q & phase_q & (cnt_q == KEY_BITS_W'(KEY_W - 1));
  // Strobe is the next-cycle phase-A indication so the top can register it.
  assign strobe_o = busy_d & ~phase_d;
  assign done_o   = last_s;
  assign busy_o   = busy_q;
  assign key_o    = key_q;

  // Next-state logic for phase, bit counter and shift register.
  always_comb begin
    busy_d  = busy_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    if (abort_i) begin
      busy_d  = 1'b0;
      phase_d = 1'b0;
    end else if (clr_i) begin
      busy_d  = 1'b0;
      phase_d = 1'b0;
      cnt_d   = '0;
      key_d   = '0;
    end else if (start_i && !busy_q) begin
      busy_d  = 1'b1;
      phase_d = 1'b0;
      cnt_d   = '0;
    end else if (busy_q && !phase_q) begin
      phase_d = 1'b1;
    end else if (busy_q && phase_q) begin
      key_d   = {key_q[KEY_W-2:0], data_i};
      phase_d = 1'b0;
      if (last_s) begin
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q + KEY_BITS_W'(1);
      end
    end else begin
      busy_d = busy_q;
    end
  end

  // Reader state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q  <= 1'b0;
      phase_q <= 1'b0;
      cnt_q   <= '0;
      key_q   <= '0;
    end else begin
      busy_q  <= busy_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
    end
  end

endmodule

// File: rtl/crypto1_sched.sv
// Scheduler for an array of Crypto1 key-search cores: sequences core reset and
// run, reads out the first recovered key and reports status and run length.
module crypto1_sched
  import crypto1_sched_pkg::*;
#(
  parameter int NCORES  = 4,
  parameter int RST_CYC = 4,
  parameter int CNT_W   = 40
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              START,
  input  logic              ABORT,
  input  logic [KEY_W-1:0]  BITSTREAM_IN,
  output logic              BUSY,
  output logic              KEY_FOUND,
  output logic              EXHAUSTED,
  output logic [KEY_W-1:0]  KEY,
  output logic [CNT_W-1:0]  CYCLES,
  output logic [KEY_W-1:0]  BITSTREAM,
  output logic              CORE_RESETn,
  input  logic [NCORES-1:0] CORE_DONE,
  input  logic [NCORES-1:0] CORE_KEY_VALID,
  input  logic [NCORES-1:0] CORE_KEY_DATA,
  output logic [NCORES-1:0] CORE_KEY_CLK
);

  localparam int RST_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  state_t            state_q;
  logic              busy_q, found_q, exh_q, core_rstn_q;
  logic [CNT_W-1:0]  cycles_q;
  logic [KEY_W-1:0]  bitstream_q;
  logic [RST_W-1:0]  rst_cnt_q;
  logic [7:0]        sel_q;
  logic [NCORES-1:0] key_clk_q;

  logic              search_start_s, rd_start_s, rd_abort_s;
  logic              rd_busy_s, rd_done_s, rd_strobe_s, rd_data_s;
  logic [7:0]        sel_prio_s, sel_d;
  logic [NCORES-1:0] key_clk_d;
  logic [CNT_W-1:0]  cycles_inc_s;

  assign search_start_s = START & ~ABORT &
                          ((state_q == ST_IDLE) | (state_q == ST_FOUND) | (state_q == ST_EXH));
  assign rd_start_s     = (state_q == ST_RUN) & (|CORE_KEY_VALID) & ~ABORT;
  assign rd_abort_s     = ABORT & (state_q != ST_IDLE);
  assign sel_prio_s     = lowest_set(256'(CORE_KEY_VALID));
  assign cycles_inc_s   = (&cycles_q) ? cycles_q : cycles_q + CNT_W'(1);

  // Selected core: freshly encoded while in RUN, frozen for the whole readout.
  always_comb begin
    if (state_q == ST_RUN) begin
      sel_d = sel_prio_s;
    end else begin
      sel_d = sel_q;
    end
  end

  // Mux the selected core's data bit in and demux the strobe out to it.
  always_comb begin
    key_clk_d = '0;
    rd_data_s = 1'b0;
    for (int i = 0; i < NCORES; i++) begin
      key_clk_d[i] = rd_strobe_s & (sel_d == 8'(i));
      rd_data_s    = rd_data_s | (CORE_KEY_DATA[i] & (sel_q == 8'(i)));
    end
  end

  crypto1_key_reader u_reader (
    .clk_i    (CLK),
    .rst_ni   (RESETn),
    .clr_i    (search_start_s),
    .start_i  (rd_start_s),
    .abort_i  (rd_abort_s),
    .data_i   (rd_data_s),
    .busy_o   (rd_busy_s),
    .done_o   (rd_done_s),
    .strobe_o (rd_strobe_s),
    .key_o    (KEY)
  );

  // Main control FSM with registered status and core-control outputs.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      found_q     <= 1'b0;
      exh_q       <= 1'b0;
      core_rstn_q <= 1'b0;
      cycles_q    <= '0;
      bitstream_q <= '0;
      rst_cnt_q   <= '0;
      sel_q       <= 8'd0;
      key_clk_q   <= '0;
    end else begin
      key_clk_q <= key_clk_d;
      if (rd_abort_s) begin
        state_q     <= ST_IDLE;
        busy_q      <= 1'b0;
        core_rstn_q <= 1'b0;
        found_q     <= 1'b0;
        exh_q       <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE, ST_FOUND, ST_EXH: begin
            if (search_start_s) begin
              bitstream_q <= BITSTREAM_IN;
              found_q     <= 1'b0;
              exh_q       <= 1'b0;
              cycles_q    <= '0;
              busy_q      <= 1'b1;
              core_rstn_q <= 1'b0;
              rst_cnt_q   <= '0;
              state_q     <= ST_RST;
            end
          end
          ST_RST: begin
            if (rst_cnt_q == RST_W'(RST_CYC - 1)) begin
              core_rstn_q <= 1'b1;
              state_q     <= ST_RUN;
            end else begin
              rst_cnt_q <= rst_cnt_q + RST_W'(1);
            end
          end
          ST_RUN: begin
            cycles_q <= cycles_inc_s;
            if (|CORE_KEY_VALID) begin
              sel_q   <= sel_d;
              state_q <= ST_SHIFT;
            end else if (&CORE_DONE) begin
              exh_q       <= 1'b1;
              busy_q      <= 1'b0;
              core_rstn_q <= 1'b0;
              state_q     <= ST_EXH;
            end
          end
          ST_SHIFT: begin
            cycles_q <= cycles_inc_s;
            if (rd_done_s) begin
              found_q     <= 1'b1;
              busy_q      <= 1'b0;
              core_rstn_q <= 1'b0;
              state_q     <= ST_FOUND;
            end else if (!rd_busy_s) begin
              // Reader lost its readout unexpectedly: park safely.
              busy_q      <= 1'b0;
              core_rstn_q <= 1'b0;
              state_q     <= ST_IDLE;
            end
          end
          default: begin
            busy_q      <= 1'b0;
            core_rstn_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign BUSY         = busy_q;
  assign KEY_FOUND    = found_q;
  assign EXHAUSTED    = exh_q;
  assign CYCLES       = cycles_q;
  assign BITSTREAM    = bitstream_q;
  assign CORE_RESETn  = core_rstn_q;
  assign CORE_KEY_CLK = key_clk_q;

endmodule

// File: doc/crypto1_sched.md
Name: crypto1_sched

Overview:
Top-level scheduler for an array of NCORES Crypto1 key-search cores, each statically assigned a different even/odd 1/256 key subspace.
- Latches the host bitstream and sequences core reset/run.
- Detects the first core that reports a key, serially clocks that core's 48-bit key out over its KEY_CLK/KEY_DATA pair, then stops the array.
- Reports found/exhausted status and a run-length cycle count to the host.

Parameters:
NCORES, 4, number of attached cores (1..256).
RST_CYC, 4, cycles CORE_RESETn is held low before a run (>=2; core reset is synchronous).
CNT_W, 40, width of the run cycle counter.

Ports:
CLK  in  1  clock; all cores share it.
RESETn  in  1  asynchronous active-low reset.
START  in  1  one-cycle request to begin a search; ignored while BUSY.
ABORT  in  1  one-cycle request to stop the current search.
BITSTREAM_IN  in  48  keystream bits for the search.
BUSY  out  1  search or key readout in progress.
KEY_FOUND  out  1  KEY holds a recovered key.
EXHAUSTED  out  1  all cores finished without a key.
KEY  out  48  recovered key, MSB first as shifted.
CYCLES  out  CNT_W  cycles spent in RUN+SHIFT, saturating.
BITSTREAM  out  48  latched bitstream broadcast to all cores.
CORE_RESETn  out  1  registered synchronous reset to all cores.
CORE_DONE  in  NCORES  per-core DONE.
CORE_KEY_VALID  in  NCORES  per-core KEY_VALID.
CORE_KEY_DATA  in  NCORES  per-core serial key bit.
CORE_KEY_CLK  out  NCORES  per-core key shift strobe.

Behaviour:
- Reset (async assert, sync release): state IDLE; BUSY=0; KEY_FOUND=0; EXHAUSTED=0; KEY=0; CYCLES=0; BITSTREAM=0; CORE_RESETn=0; CORE_KEY_CLK=0.
- All outputs are registered.
- States: IDLE, RST, RUN, SHIFT, FOUND, EXH.
- IDLE / FOUND / EXH on START (no ABORT):
  - latch BITSTREAM<=BITSTREAM_IN;
  - clear KEY, KEY_FOUND, EXHAUSTED, CYCLES;
  - BUSY<=1; go RST.
- RST: CORE_RESETn=0 for exactly RST_CYC cycles, then CORE_RESETn<=1 and go RUN.
- RUN:
  - CYCLES increments each cycle, saturating at all-ones.
  - If any CORE_KEY_VALID=1: latch sel = lowest set index, go SHIFT.
  - Else if all CORE_DONE=1: go EXH.
  - KEY_VALID takes priority over all-done in the same cycle; a core asserts DONE together with KEY_VALID.
- SHIFT: 48 bits, 2 cycles per bit, 96 cycles total.
  - Phase A: CORE_KEY_CLK[sel]=1; all other strobes stay 0.
  - Phase B: strobe 0; at the end of phase B, KEY<={KEY[46:0], CORE_KEY_DATA[sel]}.
  - Phase B accounts for the core registering KEY_DATA one cycle after it samples KEY_CLK.
  - CYCLES keeps counting.
  - After bit 47: KEY_FOUND<=1, BUSY<=0, CORE_RESETn<=0, go FOUND.
- EXH: EXHAUSTED=1, BUSY=0, CORE_RESETn=0.
- FOUND / EXH: flags, KEY and CYCLES hold until the next START.
- ABORT in any state other than IDLE:
  - next cycle: state IDLE, BUSY=0, CORE_RESETn=0, all CORE_KEY_CLK=0, KEY_FOUND=0, EXHAUSTED=0;
  - KEY and CYCLES keep their last values.
  - ABORT beats START in the same cycle.
- START while BUSY: ignored, no restart.
- CORE_KEY_VALID changes during SHIFT (another core finding a key) are ignored; sel is fixed for the readout.
- NCORES=1: sel is constant 0; behaviour is otherwise identical.

Decomposition:
- Package crypto1_sched_pkg:
  - state_t enum;
  - KEY_W=48;
  - KEY_BITS_W=$clog2(KEY_W);
  - function returning the lowest set index of a vector (priority encoder).
- Sub-module crypto1_key_reader: 2-phase strobe generator plus 48-bit shift register and bit counter.
  - Ports: start, busy, done, strobe, data_in, key.
  - The top muxes CORE_KEY_DATA[sel] into it and demuxes strobe onto CORE_KEY_CLK[sel].

Test Plan:
1. Reset mid-SHIFT (RESETn low for 1 cycle) -> immediately BUSY=0, CORE_RESETn=0, KEY=0, all CORE_KEY_CLK=0.
2. START with BITSTREAM_IN=48'h0123456789AB, NCORES=4 -> BITSTREAM latched; CORE_RESETn low exactly 4 cycles, then high; BUSY=1.
3. Core model 2 raises KEY_VALID with key 48'hA0A1A2A3A4A5 at cycle 100 of RUN -> exactly 48 CORE_KEY_CLK[2] pulses, none on other cores; KEY=48'hA0A1A2A3A4A5; KEY_FOUND=1; BUSY=0 at cycle 100+96+1 (±1 entry cycle); CORE_RESETn=0.
4. Cores 1 and 3 raise KEY_VALID in the same cycle -> core 1 is selected; only CORE_KEY_CLK[1] pulses.
5. All cores raise DONE with no KEY_VALID after 50 cycles -> EXHAUSTED=1, KEY_FOUND=0, CYCLES=50, BUSY=0.
6. ABORT and START in the same cycle during RUN -> IDLE; START ignored; BUSY=0; a later START runs normally. With CNT_W=4 and an 20-cycle run, CYCLES saturates at 15.
